// File: rtl/psg_bus_writer_pkg.sv
// Shared definitions for the PSG register-port bus writer: command entry layout,
// FSM state encoding and the helper that packs a host command into a FIFO entry.
package psg_bus_writer_pkg;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 8;
    localparam int CMD_W    = 13;
    localparam int RD_BIT   = 12;
    localparam int ADDR_MSB = 11;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;
    localparam int CNT_W    = 4;

    // Read wait spans two clocks because the PSG registers dout one clock after addr settles.
    localparam int RWAIT_CYC = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RWAIT  = 3'd4,
        ST_GAP    = 3'd5
    } state_t;

    function automatic logic [CMD_W-1:0] pack_cmd(input logic              rd,
                                                   input logic [ADDR_W-1:0] addr,
                                                   input logic [DATA_W-1:0] data);
        return {rd, addr, data};
    endfunction

endpackage

// File: rtl/psg_bus_writer_if.sv
// Host command/response handshake plus the PSG register-port pins, bundled so the
// writer and its environment share one connection point.
interface psg_bus_writer_if;
    import psg_bus_writer_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_rd;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] psg_addr;
    logic              psg_cs_n;
    logic              psg_wr_n;
    logic [DATA_W-1:0] psg_din;
    logic [DATA_W-1:0] psg_dout;
    logic              busy;

    // master: host plus PSG core side; slave: the bus writer itself
    modport master (
        output cmd_valid, cmd_rd, cmd_addr, cmd_data, psg_dout,
        input  cmd_ready, rsp_valid, rsp_data, psg_addr, psg_cs_n, psg_wr_n, psg_din, busy
    );

    modport slave (
        input  cmd_valid, cmd_rd, cmd_addr, cmd_data, psg_dout,
        output cmd_ready, rsp_valid, rsp_data, psg_addr, psg_cs_n, psg_wr_n, psg_din, busy
    );

endinterface

// File: rtl/psg_bus_writer_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; caller guarantees no push when full
// and no pop when empty.
module psg_bus_writer_cmd_fifo
    import psg_bus_writer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [CMD_W-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [CMD_W-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/psg_bus_writer.sv
// YM2149 register-port initiator: queues host read/write commands and replays each
// as a timed cs_n/wr_n bus cycle, returning read data on a one-cycle response pulse.
//
//   state  | meaning
//   IDLE   | bus released; pop next command if one is queued
//   SETUP  | cs_n low, addr/din settle before the strobe
//   STROBE | wr_n low for STROBE_CYC clocks
//   HOLD   | wr_n released, addr/din held one clock
//   RWAIT  | read: wait for registered dout, capture on last clock
//   GAP    | cs_n high for GAP_CYC clocks between transactions
module psg_bus_writer
    import psg_bus_writer_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int STROBE_CYC = 2,
    parameter int GAP_CYC    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    psg_bus_writer_if.slave     bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]    FIFO_FULL = CW'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] STROBE_TC = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_TC    = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] RWAIT_TC  = CNT_W'(RWAIT_CYC - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rd_q, rd_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  din_q, din_d;
    logic               cs_n_q, cs_n_d;
    logic               wr_n_q, wr_n_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

    logic               push;
    logic               pop;
    logic [CMD_W-1:0]   fifo_rdata;
    logic [CW-1:0]      fifo_count;

    assign push = bus.cmd_valid && bus.cmd_ready;

    psg_bus_writer_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (pack_cmd(bus.cmd_rd, bus.cmd_addr, bus.cmd_data)),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_d        = rd_q;
        addr_d      = addr_q;
        din_d       = din_q;
        pop         = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            ST_IDLE: begin
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    rd_d    = fifo_rdata[RD_BIT];
                    addr_d  = fifo_rdata[ADDR_MSB:ADDR_LSB];
                    din_d   = fifo_rdata[DATA_MSB:0];
                    cnt_d   = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (rd_q) begin
                    cnt_d   = RWAIT_TC;
                    state_d = ST_RWAIT;
                end else begin
                    cnt_d   = STROBE_TC;
                    state_d = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                cnt_d   = GAP_TC;
                state_d = ST_GAP;
            end
            ST_RWAIT: begin
                if (cnt_q == '0) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = bus.psg_dout;
                    cnt_d       = GAP_TC;
                    state_d     = ST_GAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Strobes decoded from the next state so the pins flop in step with the FSM.
        cs_n_d = (state_d == ST_IDLE) || (state_d == ST_GAP);
        wr_n_d = (state_d != ST_STROBE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            cs_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            cs_n_q      <= cs_n_d;
            wr_n_q      <= wr_n_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.cmd_ready = (fifo_count != FIFO_FULL);
    assign bus.busy      = (fifo_count != '0) || (state_q != ST_IDLE);
    assign bus.psg_addr  = addr_q;
    assign bus.psg_din   = din_q;
    assign bus.psg_cs_n  = cs_n_q;
    assign bus.psg_wr_n  = wr_n_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_psg_bus_writer.sv
// Bench for psg_bus_writer: a PSG register-file model on the bus, a transaction monitor,
// and an in-order command/register reference model checked with immediate assertions.
module tb_psg_bus_writer;

    localparam int DEPTH  = 8;
    localparam int STROBE = 2;
    localparam int GAP    = 1;

    typedef struct {
        bit         rd;
        logic [3:0] a;
        logic [7:0] d;
    } cmd_t;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] din;
        int         low_len;
        int         wr_low;
        int         falls;
        bit         stable;
        int         hi_len;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    psg_bus_writer_if bus ();

    psg_bus_writer #(
        .FIFO_DEPTH (DEPTH),
        .STROBE_CYC (STROBE),
        .GAP_CYC    (GAP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [7:0] psg_mask(input logic [3:0] a);
        case (a)
            4'd1, 4'd3, 4'd5, 4'd13: return 8'h0F;
            4'd6, 4'd8, 4'd9, 4'd10: return 8'h1F;
            default:                 return 8'hFF;
        endcase
    endfunction

    // PSG core: level-sensitive write while cs_n/wr_n low, dout registered from addr
    logic [7:0] psg_regs [16] = '{default: 8'h00};
    always @(posedge clk) begin
        if (!bus.psg_cs_n && !bus.psg_wr_n)
            psg_regs[bus.psg_addr] <= bus.psg_din & psg_mask(bus.psg_addr);
        bus.psg_dout <= psg_regs[bus.psg_addr];
    end

    // Bus monitor: one record per cs_n-low window, plus response and eg-restart tallies
    txn_t       obs_q[$];
    logic [7:0] rsp_q[$];
    int         starts = 0;
    int         eg_restarts = 0;
    bit         in_txn = 0;
    txn_t       cur;
    logic       prev_wr_n = 1'b1;
    int         hi_run = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_txn    = 0;
            hi_run    = 0;
            prev_wr_n = 1'b1;
        end else begin
            if (bus.rsp_valid === 1'b1) rsp_q.push_back(bus.rsp_data);
            if (bus.psg_cs_n === 1'b0) begin
                if (!in_txn) begin
                    in_txn      = 1;
                    starts++;
                    cur.addr    = bus.psg_addr;
                    cur.din     = bus.psg_din;
                    cur.low_len = 0;
                    cur.wr_low  = 0;
                    cur.falls   = 0;
                    cur.stable  = 1;
                    cur.hi_len  = hi_run;
                end
                cur.low_len++;
                if (bus.psg_addr !== cur.addr || bus.psg_din !== cur.din) cur.stable = 0;
                if (bus.psg_wr_n === 1'b0) begin
                    cur.wr_low++;
                    if (prev_wr_n === 1'b1) begin
                        cur.falls++;
                        if (bus.psg_addr == 4'd13) eg_restarts++;
                    end
                end
                hi_run = 0;
            end else begin
                if (in_txn) begin
                    obs_q.push_back(cur);
                    in_txn = 0;
                end
                hi_run++;
            end
            prev_wr_n = bus.psg_wr_n;
        end
    end

    cmd_t       exp_q[$];
    logic [7:0] ref_regs [16] = '{default: 8'h00};
    int         accepted = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push_cmd(input bit rd, input logic [3:0] a, input logic [7:0] d);
        int t = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_rd    = rd;
        bus.cmd_addr  = a;
        bus.cmd_data  = d;
        while (bus.cmd_ready !== 1'b1 && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 500) check("push_timeout", 32'(t), 32'd0);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        accepted++;
        exp_q.push_back('{rd: rd, a: a, d: d});
    endtask

    // Waits for the writer to go idle, then replays the expected commands in order.
    task automatic drain_and_check(input string tag);
        int         t = 0;
        int         n;
        cmd_t       c;
        txn_t       o;
        logic [7:0] r;
        while (bus.busy !== 1'b0 && t < 3000) begin
            @(negedge clk); #1;
            t++;
        end
        if (t >= 3000) check({tag, "_drain_timeout"}, 32'(t), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check({tag, "_txn_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            c = exp_q[i];
            o = obs_q[i];
            check({tag, "_addr"},    32'(o.addr),    32'(c.a));
            check({tag, "_cs_low"},  32'(o.low_len), c.rd ? 32'(1 + 2) : 32'(2 + STROBE));
            check({tag, "_wr_low"},  32'(o.wr_low),  c.rd ? 32'd0 : 32'(STROBE));
            check({tag, "_wr_fall"}, 32'(o.falls),   c.rd ? 32'd0 : 32'd1);
            check({tag, "_stable"},  32'(o.stable),  32'd1);
            check({tag, "_gap"},     32'(o.hi_len >= GAP + 1), 32'd1);
            if (!c.rd) begin
                check({tag, "_din"}, 32'(o.din), 32'(c.d));
                ref_regs[c.a] = c.d & psg_mask(c.a);
            end else if (rsp_q.size() == 0) begin
                check({tag, "_rsp_missing"}, 32'd0, 32'd1);
            end else begin
                r = rsp_q.pop_front();
                check({tag, "_rsp_data"}, 32'(r), 32'(ref_regs[c.a]));
            end
        end
        check({tag, "_rsp_extra"}, 32'(rsp_q.size()), 32'd0);
        obs_q.delete();
        exp_q.delete();
        rsp_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        int  t;
        int  n;
        int  eg0;
        bit  saw_full;
        bit  flood_done;
        int  cyc;

        bus.cmd_valid = 1'b0;
        bus.cmd_rd    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_data  = '0;

        // Reset values, then an idle bus that stays idle
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(bus.psg_cs_n), 32'd1);
        check("rst_wr_n", 32'(bus.psg_wr_n), 32'd1);
        check("rst_addr", 32'(bus.psg_addr), 32'd0);
        check("rst_din",  32'(bus.psg_din),  32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("idle_cs_n",  32'(bus.psg_cs_n),  32'd1);
            check("idle_wr_n",  32'(bus.psg_wr_n),  32'd1);
            check("idle_busy",  32'(bus.busy),      32'd0);
            check("idle_ready", 32'(bus.cmd_ready), 32'd1);
        end
        @(posedge clk); #1;

        // Single write reg8=0x0F: busy lasts five clocks from the IDLE exit
        push_cmd(1'b0, 4'd8, 8'h0F);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (bus.psg_cs_n !== 1'b0 && t < 50);
        n = 0;
        while (bus.busy === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("write_busy_len", 32'(n), 32'(1 + STROBE + 1 + GAP));
        @(posedge clk); #1;
        drain_and_check("wr8");
        push_cmd(1'b1, 4'd8, 8'h00);
        drain_and_check("rd8");

        // Write/read pairs including the reg1 mask
        push_cmd(1'b0, 4'd7, 8'h38);
        push_cmd(1'b1, 4'd7, 8'h00);
        push_cmd(1'b0, 4'd1, 8'hFF);
        push_cmd(1'b1, 4'd1, 8'h00);
        drain_and_check("wrrd");

        // Same-register back-to-back writes each strobe
        eg0 = eg_restarts;
        push_cmd(1'b0, 4'd13, 8'h0A);
        push_cmd(1'b0, 4'd13, 8'h0A);
        drain_and_check("eg13");
        check("eg_restart_count", 32'(eg_restarts - eg0), 32'd2);

        // Flood: ready must track occupancy (accepted minus started) every cycle
        saw_full   = 0;
        flood_done = 0;
        fork
            begin
                for (int i = 0; i < 20; i++)
                    push_cmd(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));
                flood_done = 1;
            end
            begin
                cyc = 0;
                while (!flood_done && cyc < 1000) begin
                    @(negedge clk); #1;
                    cyc++;
                    check("ready_vs_occupancy", 32'(bus.cmd_ready), 32'((accepted - starts) != DEPTH));
                    if (bus.cmd_ready === 1'b0) saw_full = 1;
                end
            end
        join
        check("flood_saw_full", 32'(saw_full), 32'd1);
        drain_and_check("flood");

        // Randomized commands with random idle gaps
        for (int i = 0; i < 40; i++) begin
            push_cmd(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));
            repeat ($urandom_range(0, 6)) begin
                @(posedge clk); #1;
            end
        end
        drain_and_check("random");

        // Reset during STROBE aborts at once and flushes the queue
        push_cmd(1'b0, 4'd5, 8'h11);
        push_cmd(1'b0, 4'd2, 8'h22);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (bus.psg_wr_n !== 1'b0 && t < 50);
        check("abort_reached_strobe", 32'(bus.psg_wr_n), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("abort_cs_n", 32'(bus.psg_cs_n), 32'd1);
        check("abort_wr_n", 32'(bus.psg_wr_n), 32'd1);
        check("abort_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        obs_q.delete();
        exp_q.delete();
        rsp_q.delete();
        accepted = starts;
        @(posedge clk); #1;
        check("abort_ready", 32'(bus.cmd_ready), 32'd1);
        repeat (4) @(negedge clk);
        check("abort_no_replay", 32'(obs_q.size() + (bus.busy === 1'b1 ? 1 : 0)), 32'd0);
        @(posedge clk); #1;
        push_cmd(1'b0, 4'd5, 8'h2C);
        push_cmd(1'b1, 4'd5, 8'h00);
        drain_and_check("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
